// File: rtl/pmem_sequencer_if.sv
// Bundle between the loader/debug unit, the fetch stage and the program-memory port.
interface pmem_sequencer_if #(parameter int unsigned AW = 10);
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic          cmd_run;
  logic          cmd_step;
  logic          cmd_halt;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_instruction;
  logic          pmem_we;
  logic [AW-1:0] pmem_addr;
  logic [31:0]   pmem_wdata;
  logic          pc_enable;
  logic          pc_clear;
  logic          step_done;
  logic          halted;
  logic          load_overflow;
  logic [31:0]   cycle_count;
  logic [2:0]    state;

  modport slave (
    input  load_valid, load_data, load_last, cmd_run, cmd_step, cmd_halt,
           fetch_addr, fetch_instruction,
    output load_ready, pmem_we, pmem_addr, pmem_wdata, pc_enable, pc_clear,
           step_done, halted, load_overflow, cycle_count, state
  );

  modport master (
    output load_valid, load_data, load_last, cmd_run, cmd_step, cmd_halt,
           fetch_addr, fetch_instruction,
    input  load_ready, pmem_we, pmem_addr, pmem_wdata, pc_enable, pc_clear,
           step_done, halted, load_overflow, cycle_count, state
  );
endinterface

// File: rtl/pmem_sequencer.sv
// Fetch-stage sequencer: arbitrates the pmem port between the program loader and
// PC-driven fetch, gates PC advance (run/step) and detects the halt word.
module pmem_sequencer #(
  parameter int unsigned AW        = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic             clock,
  input logic             reset,
  pmem_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CLEAR  = 3'd2,
    RUN    = 3'd3,
    STEP   = 3'd4,
    HALTED = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          ovf_q, ovf_d;
  logic          step_done_q, step_done_d;
  logic          pc_en;
  logic          halt_word;
  logic          accept;

  assign halt_word = (bus.fetch_instruction == HALT_WORD);
  assign accept    = (state_q == LOAD) && bus.load_valid;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cycle_d     = cycle_q;
    ovf_d       = ovf_q;
    step_done_d = 1'b0;
    pc_en       = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (bus.load_valid) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          cycle_d  = '0;
          ovf_d    = 1'b0;
        end else if (state_q == IDLE) begin
          if (bus.cmd_run)       state_d = RUN;
          else if (bus.cmd_step) state_d = STEP;
        end
      end
      LOAD: begin
        if (accept) begin
          // Overflow ends the load exactly like load_last; the extra word stalls until the next LOAD.
          if (bus.load_last || (wr_ptr_q == '1)) begin
            state_d  = CLEAR;
            wr_ptr_d = '0;
            if (!bus.load_last) ovf_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      CLEAR: state_d = IDLE;
      RUN: begin
        pc_en = !halt_word && !bus.cmd_halt;
        if (halt_word)         state_d = HALTED;
        else if (bus.cmd_halt) state_d = IDLE;
      end
      STEP: begin
        if (halt_word) begin
          state_d = HALTED;
        end else begin
          pc_en       = 1'b1;
          step_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pc_en) cycle_d = cycle_d + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cycle_q     <= '0;
      ovf_q       <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cycle_q     <= cycle_d;
      ovf_q       <= ovf_d;
      step_done_q <= step_done_d;
    end
  end

  assign bus.load_ready    = (state_q == LOAD);
  assign bus.pmem_we       = accept;
  assign bus.pmem_addr     = (state_q == LOAD) ? wr_ptr_q : bus.fetch_addr;
  assign bus.pmem_wdata    = accept ? bus.load_data : '0;
  assign bus.pc_enable     = pc_en;
  assign bus.pc_clear      = (state_q == CLEAR);
  assign bus.step_done     = step_done_q;
  assign bus.halted        = (state_q == HALTED);
  assign bus.load_overflow = ovf_q;
  assign bus.cycle_count   = cycle_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_pmem_sequencer.sv
// Self-checking bench for pmem_sequencer: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_pmem_sequencer;
  localparam int unsigned AW    = 10;
  localparam int unsigned SAW   = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [AW-1:0] FA  = 10'h155;
  localparam logic T = 1'b1, F = 1'b0;
  localparam logic [2:0] SI = 3'd0, SL = 3'd1, SC = 3'd2, SR = 3'd3, SS = 3'd4, SH = 3'd5;
  localparam int M_IDLE = 0, M_LOAD = 1, M_CLEAR = 2, M_RUN = 3, M_STEP = 4, M_HALTED = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pmem_sequencer_if #(.AW(AW))  bus ();
  pmem_sequencer_if #(.AW(SAW)) sbus ();

  pmem_sequencer #(.AW(AW), .HALT_WORD(HALTW)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  pmem_sequencer #(.AW(SAW), .HALT_WORD(HALTW)) dut_s (
    .clock(clock), .reset(reset), .bus(sbus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]    st;
    logic          rdy, we;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          en, clr, done, hlt, ovf;
    logic [31:0]   cc;
  } exp_t;

  typedef struct {
    logic lv; logic [31:0] ld; logic ll, run, step, halt; logic [31:0] fi;
    logic [2:0] st; logic rdy, we; logic [AW-1:0] addr;
    logic en, clr, done, hlt; logic [31:0] cc;
  } vec_t;

  vec_t tbl [25];

  int          m_mode;
  int unsigned m_wptr;
  logic [31:0] m_cc;
  logic        m_ovf, m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input exp_t e);
    chk({tag, ".state"},     32'(bus.state),         32'(e.st));
    chk({tag, ".load_ready"},32'(bus.load_ready),    32'(e.rdy));
    chk({tag, ".pmem_we"},   32'(bus.pmem_we),       32'(e.we));
    chk({tag, ".pmem_addr"}, 32'(bus.pmem_addr),     32'(e.addr));
    if (e.we) chk({tag, ".pmem_wdata"}, bus.pmem_wdata, e.wd);
    chk({tag, ".pc_enable"}, 32'(bus.pc_enable),     32'(e.en));
    chk({tag, ".pc_clear"},  32'(bus.pc_clear),      32'(e.clr));
    chk({tag, ".step_done"}, 32'(bus.step_done),     32'(e.done));
    chk({tag, ".halted"},    32'(bus.halted),        32'(e.hlt));
    chk({tag, ".overflow"},  32'(bus.load_overflow), 32'(e.ovf));
    chk({tag, ".cycles"},    bus.cycle_count,        e.cc);
  endtask

  task automatic idle_inputs();
    bus.load_valid = F; bus.load_data = '0; bus.load_last = F;
    bus.cmd_run = F; bus.cmd_step = F; bus.cmd_halt = F;
    bus.fetch_addr = FA; bus.fetch_instruction = NOP;
  endtask

  task automatic sidle();
    sbus.load_valid = F; sbus.load_data = '0; sbus.load_last = F;
    sbus.cmd_run = F; sbus.cmd_step = F; sbus.cmd_halt = F;
    sbus.fetch_addr = 2'd1; sbus.fetch_instruction = NOP;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    exp_t e;
    bus.load_valid = v.lv; bus.load_data = v.ld; bus.load_last = v.ll;
    bus.cmd_run = v.run; bus.cmd_step = v.step; bus.cmd_halt = v.halt;
    bus.fetch_addr = FA; bus.fetch_instruction = v.fi;
    e = '{v.st, v.rdy, v.we, v.addr, v.ld, v.en, v.clr, v.done, v.hlt, F, v.cc};
    @(negedge clock);
    check_main($sformatf("vec%0d", idx), e);
    @(posedge clock); #1;
  endtask

  task automatic zero_after_reset(input string tag);
    exp_t e;
    e = '{SI, F, F, FA, 32'd0, F, F, F, F, F, 32'd0};
    check_main(tag, e);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_wptr = 0; m_cc = '0; m_ovf = F; m_done = F;
  endtask

  task automatic rand_cycle(input int idx);
    exp_t e;
    logic hw, fire, en;
    bus.load_valid = (m_mode == M_LOAD) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 11) == 0);
    bus.load_data  = $urandom;
    bus.load_last  = ($urandom_range(0, 15) == 0);
    bus.cmd_run    = ($urandom_range(0, 9) < 3);
    bus.cmd_step   = ($urandom_range(0, 9) < 3);
    bus.cmd_halt   = ($urandom_range(0, 9) == 0);
    bus.fetch_addr = AW'($urandom);
    bus.fetch_instruction = ($urandom_range(0, 11) == 0) ? HALTW : $urandom;
    @(negedge clock);
    hw   = (bus.fetch_instruction == HALTW);
    fire = (m_mode == M_LOAD) && bus.load_valid;
    en   = ((m_mode == M_RUN) && !hw && !bus.cmd_halt) || ((m_mode == M_STEP) && !hw);
    e.st   = 3'(m_mode);
    e.rdy  = (m_mode == M_LOAD);
    e.we   = fire;
    e.addr = (m_mode == M_LOAD) ? AW'(m_wptr) : bus.fetch_addr;
    e.wd   = bus.load_data;
    e.en   = en;
    e.clr  = (m_mode == M_CLEAR);
    e.done = m_done;
    e.hlt  = (m_mode == M_HALTED);
    e.ovf  = m_ovf;
    e.cc   = m_cc;
    check_main($sformatf("rnd%0d", idx), e);
    @(posedge clock);
    m_done = (m_mode == M_STEP) && !hw;
    if (en) m_cc = m_cc + 32'd1;
    case (m_mode)
      M_IDLE, M_HALTED: begin
        if (bus.load_valid) begin
          m_mode = M_LOAD; m_wptr = 0; m_cc = '0; m_ovf = F;
        end else if (m_mode == M_IDLE && bus.cmd_run) m_mode = M_RUN;
        else if (m_mode == M_IDLE && bus.cmd_step) m_mode = M_STEP;
      end
      M_LOAD: if (bus.load_valid) begin
        if (bus.load_last) begin
          m_mode = M_CLEAR; m_wptr = 0;
        end else if (m_wptr == DEPTH - 1) begin
          m_mode = M_CLEAR; m_wptr = 0; m_ovf = T;
        end else begin
          m_wptr = m_wptr + 1;
        end
      end
      M_CLEAR: m_mode = M_IDLE;
      M_RUN: begin
        if (hw) m_mode = M_HALTED;
        else if (bus.cmd_halt) m_mode = M_IDLE;
      end
      M_STEP: m_mode = hw ? M_HALTED : M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    #1;
  endtask

  initial begin
    //            lv ld            ll run step halt fi     st rdy we addr    en clr done hlt cc
    tbl[0]  = '{F, 32'h0,        F, F, F, F, NOP,   SI, F, F, FA,    F, F, F, F, 32'd0};
    tbl[1]  = '{T, 32'h20010001, F, F, F, F, NOP,   SI, F, F, FA,    F, F, F, F, 32'd0};
    tbl[2]  = '{T, 32'h20010001, F, F, F, F, NOP,   SL, T, T, 10'd0, F, F, F, F, 32'd0};
    tbl[3]  = '{T, 32'h20010002, F, F, F, F, NOP,   SL, T, T, 10'd1, F, F, F, F, 32'd0};
    tbl[4]  = '{T, 32'h20010003, F, F, F, F, NOP,   SL, T, T, 10'd2, F, F, F, F, 32'd0};
    tbl[5]  = '{T, 32'h20010004, T, F, F, F, NOP,   SL, T, T, 10'd3, F, F, F, F, 32'd0};
    tbl[6]  = '{F, 32'h0,        F, F, F, F, NOP,   SC, F, F, FA,    F, T, F, F, 32'd0};
    tbl[7]  = '{F, 32'h0,        F, T, F, F, NOP,   SI, F, F, FA,    F, F, F, F, 32'd0};
    tbl[8]  = '{F, 32'h0,        F, T, F, F, NOP,   SR, F, F, FA,    T, F, F, F, 32'd0};
    tbl[9]  = '{F, 32'h0,        F, T, F, F, NOP,   SR, F, F, FA,    T, F, F, F, 32'd1};
    tbl[10] = '{F, 32'h0,        F, T, F, F, NOP,   SR, F, F, FA,    T, F, F, F, 32'd2};
    tbl[11] = '{F, 32'h0,        F, T, F, F, NOP,   SR, F, F, FA,    T, F, F, F, 32'd3};
    tbl[12] = '{F, 32'h0,        F, T, F, F, NOP,   SR, F, F, FA,    T, F, F, F, 32'd4};
    tbl[13] = '{F, 32'h0,        F, T, F, F, HALTW, SR, F, F, FA,    F, F, F, F, 32'd5};
    tbl[14] = '{F, 32'h0,        F, T, F, F, NOP,   SH, F, F, FA,    F, F, F, T, 32'd5};
    tbl[15] = '{F, 32'h0,        F, T, T, T, NOP,   SH, F, F, FA,    F, F, F, T, 32'd5};
    tbl[16] = '{T, 32'h20020001, T, F, F, F, NOP,   SH, F, F, FA,    F, F, F, T, 32'd5};
    tbl[17] = '{T, 32'h20020001, T, F, F, F, NOP,   SL, T, T, 10'd0, F, F, F, F, 32'd0};
    tbl[18] = '{F, 32'h0,        F, F, F, F, NOP,   SC, F, F, FA,    F, T, F, F, 32'd0};
    tbl[19] = '{F, 32'h0,        F, F, T, F, NOP,   SI, F, F, FA,    F, F, F, F, 32'd0};
    tbl[20] = '{F, 32'h0,        F, F, F, F, NOP,   SS, F, F, FA,    T, F, F, F, 32'd0};
    tbl[21] = '{F, 32'h0,        F, F, F, F, NOP,   SI, F, F, FA,    F, F, T, F, 32'd1};
    tbl[22] = '{F, 32'h0,        F, F, T, F, HALTW, SI, F, F, FA,    F, F, F, F, 32'd1};
    tbl[23] = '{F, 32'h0,        F, F, F, F, HALTW, SS, F, F, FA,    F, F, F, F, 32'd1};
    tbl[24] = '{F, 32'h0,        F, F, F, F, NOP,   SH, F, F, FA,    F, F, F, T, 32'd1};

    idle_inputs();
    sidle();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    zero_after_reset("reset");
    reset = 1'b1;
    @(posedge clock); #1;

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // Reset in the middle of a load: two words written, then async reset without a clock edge.
    bus.load_valid = T; bus.load_data = 32'h3000_0000;
    @(posedge clock); #1;
    for (int k = 0; k < 2; k++) begin
      bus.load_data = 32'h3000_0000 + 32'(k);
      @(negedge clock);
      chk($sformatf("midload%0d.we", k), 32'(bus.pmem_we), 32'(T));
      chk($sformatf("midload%0d.addr", k), 32'(bus.pmem_addr), k);
      @(posedge clock); #1;
    end
    #2 reset = 1'b0;
    #1 zero_after_reset("async_load");
    idle_inputs();
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    // Reset in the middle of RUN with a nonzero cycle count.
    bus.cmd_run = T;
    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("midrun.en", 32'(bus.pc_enable), 32'(T));
    chk("midrun.cycles", bus.cycle_count, 32'd2);
    #2 reset = 1'b0;
    #1 zero_after_reset("async_run");
    idle_inputs();
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    // HALT_WORD and cmd_halt in the same RUN cycle: halt word wins.
    bus.cmd_run = T;
    @(posedge clock); #1;
    bus.cmd_run = F;
    @(negedge clock);
    chk("simul.run_en", 32'(bus.pc_enable), 32'(T));
    @(posedge clock); #1;
    bus.fetch_instruction = HALTW; bus.cmd_halt = T;
    @(negedge clock);
    chk("simul.en", 32'(bus.pc_enable), 32'(F));
    chk("simul.state_run", 32'(bus.state), 32'(SR));
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    chk("simul.state", 32'(bus.state), 32'(SH));
    chk("simul.halted", 32'(bus.halted), 32'(T));
    @(posedge clock); #1;

    // Overflow on the 4-word instance: five words streamed without load_last.
    sbus.load_valid = T; sbus.load_data = 32'h5000_0000;
    @(negedge clock);
    chk("ovf.idle_ready", 32'(sbus.load_ready), 32'(F));
    @(posedge clock); #1;
    for (int k = 0; k < 4; k++) begin
      sbus.load_data = 32'h5000_0000 + 32'(k);
      @(negedge clock);
      chk($sformatf("ovf%0d.we", k), 32'(sbus.pmem_we), 32'(T));
      chk($sformatf("ovf%0d.addr", k), 32'(sbus.pmem_addr), k);
      chk($sformatf("ovf%0d.wdata", k), sbus.pmem_wdata, 32'h5000_0000 + 32'(k));
      chk($sformatf("ovf%0d.flag", k), 32'(sbus.load_overflow), 32'(F));
      @(posedge clock); #1;
    end
    sbus.load_data = 32'h5000_0004;
    @(negedge clock);
    chk("ovf.clear", 32'(sbus.pc_clear), 32'(T));
    chk("ovf.flag", 32'(sbus.load_overflow), 32'(T));
    chk("ovf.stall_ready", 32'(sbus.load_ready), 32'(F));
    chk("ovf.stall_we", 32'(sbus.pmem_we), 32'(F));
    @(posedge clock); #1;
    @(negedge clock);
    chk("ovf.idle_state", 32'(sbus.state), 32'(SI));
    chk("ovf.idle_ready2", 32'(sbus.load_ready), 32'(F));
    chk("ovf.sticky", 32'(sbus.load_overflow), 32'(T));
    @(posedge clock); #1;
    sbus.load_last = T;
    @(negedge clock);
    chk("ovf.reload_ready", 32'(sbus.load_ready), 32'(T));
    chk("ovf.reload_addr", 32'(sbus.pmem_addr), 32'd0);
    chk("ovf.reload_wdata", sbus.pmem_wdata, 32'h5000_0004);
    chk("ovf.reload_flag", 32'(sbus.load_overflow), 32'(F));
    @(posedge clock); #1;
    sidle();
    @(negedge clock);
    chk("ovf.reload_clear", 32'(sbus.pc_clear), 32'(T));
    @(posedge clock); #1;

    // Randomized run against the behavioural model.
    #2 reset = 1'b0;
    model_reset();
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3000; i++) rand_cycle(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
